fetch_prefetch_buffer: RTL

- Parametrised fetch stage for the pipelined core: owns the fetch PC, issues requests to the synchronous-read instruction memory, and buffers returned instructions in a DEPTH-entry FIFO.
- Hands {instruction, PC, PC+4} to the decode pipeline register under a stall handshake.
- Supports redirect (branch/jump taken in Execute), which flushes buffered and in-flight fetches.

---
 rtl/fetch_prefetch_buffer_if.sv | 31 +++
 rtl/fetch_prefetch_buffer.sv | 106 ++++++++++
 2 files changed

// File: rtl/fetch_prefetch_buffer_if.sv
// Fetch-stage bus: instruction-memory request/response, redirect, and the head
// of the prefetch FIFO presented to decode.
interface fetch_prefetch_buffer_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4
);
  localparam int COUNT_WIDTH = $clog2(DEPTH + 1);

  logic                     imem_req;
  logic [ADDRESS_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0]    imem_rdata;
  logic                     redirect;
  logic [ADDRESS_WIDTH-1:0] redirect_pc;
  logic                     stall;
  logic                     instr_valid;
  logic [DATA_WIDTH-1:0]    instrF;
  logic [ADDRESS_WIDTH-1:0] pcF;
  logic [ADDRESS_WIDTH-1:0] pcplus4F;
  logic [COUNT_WIDTH-1:0]   count;

  modport master (
    output imem_req, imem_addr, instr_valid, instrF, pcF, pcplus4F, count,
    input  imem_rdata, redirect, redirect_pc, stall
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instrF, pcF, pcplus4F, count,
    output imem_rdata, redirect, redirect_pc, stall
  );
endinterface

// File: rtl/fetch_prefetch_buffer.sv
// Fetch stage: owns the fetch PC, issues credit-limited reads to a synchronous
// instruction memory and buffers responses in a DEPTH-entry FIFO for decode.
module fetch_prefetch_buffer #(
  parameter int                       ADDRESS_WIDTH = 8,
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       DEPTH         = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input logic                      clk,
  input logic                      rst,
  fetch_prefetch_buffer_if.master  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [ADDRESS_WIDTH-1:0] fetchPc;
  logic [ADDRESS_WIDTH-1:0] reqPc;
  logic                     pending;
  logic [DATA_WIDTH-1:0]    instrMem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] pcMem    [DEPTH];
  logic [PW-1:0]            wrPtr;
  logic [PW-1:0]            rdPtr;
  logic [PW-1:0]            rdPtrNext;
  logic [CW-1:0]            cnt;
  logic [CW-1:0]            cntNext;
  logic [CW:0]              credit;
  logic [DATA_WIDTH-1:0]    headInstr;
  logic [ADDRESS_WIDTH-1:0] headPc;
  logic [ADDRESS_WIDTH-1:0] headPc4;
  logic                     headValid;
  logic                     pop;
  logic                     push;
  logic                     req;

  function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Occupancy counts the in-flight response so the FIFO can never overflow.
  always_comb begin
    headValid = (cnt != '0) & ~bus.redirect;
    pop       = headValid & ~bus.stall;
    push      = pending & ~bus.redirect;
    credit    = {1'b0, cnt} + {{CW{1'b0}}, pending} - {{CW{1'b0}}, pop};
    req       = ~rst & ~bus.redirect & (credit < (CW + 1)'(DEPTH));
    rdPtrNext = pop ? ptrInc(rdPtr) : rdPtr;
    cntNext   = cnt + {{(CW - 1){1'b0}}, push} - {{(CW - 1){1'b0}}, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetchPc   <= RESET_PC;
      reqPc     <= '0;
      pending   <= 1'b0;
      wrPtr     <= '0;
      rdPtr     <= '0;
      cnt       <= '0;
      headInstr <= '0;
      headPc    <= '0;
      headPc4   <= '0;
    end else if (bus.redirect) begin
      fetchPc <= bus.redirect_pc;
      pending <= 1'b0;
      wrPtr   <= '0;
      rdPtr   <= '0;
      cnt     <= '0;
    end else begin
      pending <= req;
      if (req) begin
        reqPc   <= fetchPc;
        fetchPc <= fetchPc + ADDRESS_WIDTH'(4);
      end
      if (push) wrPtr <= ptrInc(wrPtr);
      rdPtr <= rdPtrNext;
      cnt   <= cntNext;
      // Head registers track the next head; when the slot being written is the
      // next head, take the incoming response directly. Empty FIFO holds.
      if (cntNext != '0) begin
        if (push && (wrPtr == rdPtrNext)) begin
          headInstr <= bus.imem_rdata;
          headPc    <= reqPc;
          headPc4   <= reqPc + ADDRESS_WIDTH'(4);
        end else begin
          headInstr <= instrMem[rdPtrNext];
          headPc    <= pcMem[rdPtrNext];
          headPc4   <= pcMem[rdPtrNext] + ADDRESS_WIDTH'(4);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instrMem[wrPtr] <= bus.imem_rdata;
      pcMem[wrPtr]    <= reqPc;
    end
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = fetchPc;
  assign bus.instr_valid = headValid;
  assign bus.instrF      = headInstr;
  assign bus.pcF         = headPc;
  assign bus.pcplus4F    = headPc4;
  assign bus.count       = cnt;
endmodule
